// File: rtl/mem_wb_pkg.sv
// Shared encodings for the memory-access / write-back stage:
// write-back select codes, RV32I load/store funct3 codes and the FSM states.
package mem_wb_pkg;

  localparam logic [1:0] WB_MEM  = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_ALU2 = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  // Unused funct3 encodings (011/110/111) fall through to word accesses.
  function automatic size_t access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Picks the addressed byte/halfword lane out of a read word and
// sign- or zero-extends it according to the load funct3.
module load_extend
  import mem_wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    ext = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   ext = {24'b0, byte_lane};
      F3_H:    ext = {{16{half_lane[15]}}, half_lane};
      F3_HU:   ext = {16'b0, half_lane};
      F3_W:    ext = rdata;
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access + write-back stage: issues loads/stores over a req/ready
// handshake, stalls fetch while waiting and selects the register write-back value.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] ALUOut,
  input  logic [31:0] DataOutReg2,
  input  logic [31:0] PC,
  input  logic [2:0]  funct3,
  input  logic        MemWE,
  input  logic [1:0]  WBSel,
  input  logic        RegWE,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_o,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteAddr,
  output logic        we,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [31:0]   lat_addr, lat_wdata;
  logic [3:0]    lat_be;
  logic [2:0]    lat_funct3;
  logic [4:0]    lat_rd;
  logic          lat_regwe, lat_memwe;

  size_t       size;
  logic        mem_op, misaligned, accept, timeout;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, load_value;

  assign size    = access_size(funct3);
  assign mem_op  = valid_i & (MemWE | (WBSel == WB_MEM));
  assign accept  = (state == ST_IDLE) & mem_op & ~misaligned;
  assign timeout = (state == ST_WAIT) & ~dmem_ready & (count == CNT_LAST);

  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = DataOutReg2;
    case (size)
      SZ_BYTE: begin
        be_calc    = 4'b0001 << ALUOut[1:0];
        wdata_calc = {4{DataOutReg2[7:0]}};
      end
      SZ_HALF: begin
        misaligned = ALUOut[0];
        be_calc    = 4'b0011 << {ALUOut[1], 1'b0};
        wdata_calc = {2{DataOutReg2[15:0]}};
      end
      default: misaligned = (ALUOut[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_WAIT;
      ST_WAIT: if (dmem_ready || timeout) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields are captured at accept and held for the whole WAIT phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      lat_funct3 <= '0;
      lat_rd     <= '0;
      lat_regwe  <= 1'b0;
      lat_memwe  <= 1'b0;
    end else if (accept) begin
      count      <= '0;
      lat_addr   <= ALUOut;
      lat_wdata  <= wdata_calc;
      lat_be     <= be_calc;
      lat_funct3 <= funct3;
      lat_rd     <= rd;
      lat_regwe  <= RegWE;
      lat_memwe  <= MemWE;
    end else if (state == ST_WAIT) begin
      count <= (dmem_ready || timeout) ? '0 : count + 1'b1;
    end
  end

  load_extend u_load_extend (
    .rdata   (dmem_rdata),
    .addr_lo (lat_addr[1:0]),
    .funct3  (lat_funct3),
    .ext     (load_value)
  );

  // Outputs are forced quiet while reset is held, even with valid EX inputs.
  always_comb begin
    stall_o    = 1'b0;
    we         = 1'b0;
    WriteData  = '0;
    WriteAddr  = '0;
    misalign_o = 1'b0;
    bus_err_o  = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          if (mem_op) begin
            misalign_o = misaligned;
            stall_o    = ~misaligned;
          end else if (valid_i) begin
            we        = RegWE & (rd != 5'd0);
            WriteAddr = rd;
            case (WBSel)
              WB_PC4:          WriteData = PC + 32'd4;
              WB_ALU, WB_ALU2: WriteData = ALUOut;
              default:         WriteData = '0;
            endcase
          end
        end
        ST_WAIT: begin
          if (dmem_ready) begin
            if (!lat_memwe && lat_regwe && (lat_rd != 5'd0)) begin
              we        = 1'b1;
              WriteAddr = lat_rd;
              WriteData = load_value;
            end
          end else if (timeout) begin
            bus_err_o = 1'b1;
          end else begin
            stall_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req   = (state == ST_WAIT);
  assign dmem_we    = dmem_req & lat_memwe;
  assign dmem_addr  = {lat_addr[31:2], 2'b00};
  assign dmem_wdata = lat_wdata;
  assign dmem_be    = lat_be;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: table of single-cycle IDLE vectors plus
// hand-written load/store/timeout/reset sequences.
module tb_mem_wb_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] ALUOut, DataOutReg2, PC;
  logic [2:0]  funct3;
  logic        MemWE;
  logic [1:0]  WBSel;
  logic        RegWE;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall_o;
  logic [31:0] WriteData;
  logic [4:0]  WriteAddr;
  logic        we, misalign_o, bus_err_o;

  int nChecks = 0;
  int nMiscompares = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ALUOut(ALUOut),
    .DataOutReg2(DataOutReg2), .PC(PC), .funct3(funct3), .MemWE(MemWE),
    .WBSel(WBSel), .RegWE(RegWE), .rd(rd), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_o(stall_o), .WriteData(WriteData), .WriteAddr(WriteAddr),
    .we(we), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic        memwe;
    logic [1:0]  wbsel;
    logic        regwe;
    logic [4:0]  rd;
    logic        chkData;
    logic        expWe;
    logic [31:0] expData;
    logic [4:0]  expAddr;
    logic        expStall;
    logic        expMis;
  } vec_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [4:0]  delay;
    logic [4:0]  rd;
    logic [31:0] expData;
  } load_t;

  vec_t  vecs[13];
  load_t loads[7];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    @(negedge clk);
    valid_i = v.valid; ALUOut = v.alu; PC = v.pc; funct3 = v.f3;
    MemWE = v.memwe; WBSel = v.wbsel; RegWE = v.regwe; rd = v.rd;
    DataOutReg2 = 32'h0BAD_F00D;
    #2;
    checkOutput($sformatf("vec%0d we", idx), we, v.expWe);
    checkOutput($sformatf("vec%0d stall", idx), stall_o, v.expStall);
    checkOutput($sformatf("vec%0d misalign", idx), misalign_o, v.expMis);
    if (v.chkData) begin
      checkOutput($sformatf("vec%0d WriteData", idx), WriteData, v.expData);
      checkOutput($sformatf("vec%0d WriteAddr", idx), WriteAddr, v.expAddr);
    end
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d no req", idx), dmem_req, 1'b0);
  endtask

  task automatic runLoad(input int idx, input load_t L);
    @(negedge clk);
    valid_i = 1'b1; MemWE = 1'b0; WBSel = 2'b00; RegWE = 1'b1; rd = L.rd;
    funct3 = L.f3; ALUOut = L.addr; dmem_ready = 1'b0;
    #2;
    checkOutput($sformatf("ld%0d accept stall", idx), stall_o, 1'b1);
    checkOutput($sformatf("ld%0d accept we", idx), we, 1'b0);
    checkOutput($sformatf("ld%0d accept req", idx), dmem_req, 1'b0);
    @(negedge clk); #2;
    checkOutput($sformatf("ld%0d req", idx), dmem_req, 1'b1);
    checkOutput($sformatf("ld%0d dmem_we", idx), dmem_we, 1'b0);
    checkOutput($sformatf("ld%0d addr", idx), dmem_addr, {L.addr[31:2], 2'b00});
    for (int i = 0; i < int'(L.delay); i++) begin
      checkOutput($sformatf("ld%0d wait stall", idx), stall_o, 1'b1);
      @(negedge clk); #2;
    end
    dmem_ready = 1'b1; dmem_rdata = L.rdata;
    #1;
    checkOutput($sformatf("ld%0d ready stall", idx), stall_o, 1'b0);
    checkOutput($sformatf("ld%0d ready bus_err", idx), bus_err_o, 1'b0);
    checkOutput($sformatf("ld%0d we", idx), we, 1'b1);
    checkOutput($sformatf("ld%0d WriteData", idx), WriteData, L.expData);
    checkOutput($sformatf("ld%0d WriteAddr", idx), WriteAddr, L.rd);
    @(negedge clk);
    dmem_ready = 1'b0; valid_i = 1'b0;
    #2;
    checkOutput($sformatf("ld%0d req dropped", idx), dmem_req, 1'b0);
  endtask

  task automatic runStore(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [3:0] expBe,
                          input logic [31:0] expWdata);
    @(negedge clk);
    valid_i = 1'b1; MemWE = 1'b1; WBSel = 2'b01; RegWE = 1'b1; rd = 5'd9;
    funct3 = f3; ALUOut = addr; DataOutReg2 = rs2; dmem_ready = 1'b0;
    #2;
    checkOutput({name, " accept stall"}, stall_o, 1'b1);
    checkOutput({name, " accept we"}, we, 1'b0);
    @(negedge clk); #2;
    checkOutput({name, " req"}, dmem_req, 1'b1);
    checkOutput({name, " dmem_we"}, dmem_we, 1'b1);
    checkOutput({name, " addr"}, dmem_addr, {addr[31:2], 2'b00});
    checkOutput({name, " be"}, dmem_be, expBe);
    checkOutput({name, " wdata"}, dmem_wdata, expWdata);
    checkOutput({name, " wait stall"}, stall_o, 1'b1);
    @(negedge clk);
    dmem_ready = 1'b1;
    #2;
    checkOutput({name, " ready stall"}, stall_o, 1'b0);
    checkOutput({name, " no writeback"}, we, 1'b0);
    checkOutput({name, " held be"}, dmem_be, expBe);
    @(negedge clk);
    dmem_ready = 1'b0; valid_i = 1'b0;
    #2;
    checkOutput({name, " req dropped"}, dmem_req, 1'b0);
  endtask

  initial begin
    int n;
    int stallDrops;

    //           valid alu            pc             f3      mw wb     rwe rd     chk  we data          addr   st mis
    vecs[0]  = '{1'b1, 32'h0000_1234, 32'h0,         3'b000, 1'b0, 2'b01, 1'b1, 5'd5,  1'b1, 1'b1, 32'h0000_1234, 5'd5,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0,         32'h0000_0100, 3'b000, 1'b0, 2'b10, 1'b1, 5'd1,  1'b1, 1'b1, 32'h0000_0104, 5'd1,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'hDEAD_BEEF, 32'h0,         3'b000, 1'b0, 2'b11, 1'b1, 5'd31, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0055, 32'h0,         3'b000, 1'b0, 2'b01, 1'b1, 5'd0,  1'b1, 1'b0, 32'h0000_0055, 5'd0,  1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0077, 32'h0,         3'b000, 1'b0, 2'b01, 1'b0, 5'd7,  1'b1, 1'b0, 32'h0000_0077, 5'd7,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0099, 32'h0,         3'b000, 1'b0, 2'b01, 1'b1, 5'd8,  1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h0,         32'hFFFF_FFFC, 3'b000, 1'b0, 2'b10, 1'b1, 5'd2,  1'b1, 1'b1, 32'h0000_0000, 5'd2,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0006, 32'h0,         3'b010, 1'b0, 2'b00, 1'b1, 5'd3,  1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0021, 32'h0,         3'b001, 1'b1, 2'b01, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b1};
    vecs[9]  = '{1'b1, 32'h0000_0003, 32'h0,         3'b001, 1'b0, 2'b00, 1'b1, 5'd4,  1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_0002, 32'h0,         3'b010, 1'b1, 2'b01, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b1};
    vecs[11] = '{1'b1, 32'h0000_0005, 32'h0,         3'b101, 1'b0, 2'b00, 1'b1, 5'd6,  1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b1};
    vecs[12] = '{1'b1, 32'h0000_0001, 32'h0,         3'b011, 1'b0, 2'b00, 1'b1, 5'd6,  1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b1};

    //           f3      addr           rdata          delay   rd      expected
    loads[0] = '{3'b000, 32'h0000_0013, 32'h80FF_0000, 5'd0,  5'd10, 32'hFFFF_FF80};
    loads[1] = '{3'b100, 32'h0000_0012, 32'h80FF_0000, 5'd2,  5'd11, 32'h0000_00FF};
    loads[2] = '{3'b001, 32'h0000_0022, 32'h80FF_0000, 5'd1,  5'd12, 32'hFFFF_80FF};
    loads[3] = '{3'b101, 32'h0000_0010, 32'h1234_8001, 5'd0,  5'd13, 32'h0000_8001};
    loads[4] = '{3'b010, 32'h0000_0040, 32'hCAFE_BABE, 5'd3,  5'd14, 32'hCAFE_BABE};
    loads[5] = '{3'b001, 32'h0000_0000, 32'h0000_7FFF, 5'd0,  5'd15, 32'h0000_7FFF};
    loads[6] = '{3'b010, 32'h0000_0080, 32'h0102_0304, 5'(TIMEOUT - 1), 5'd16, 32'h0102_0304};

    rst = 1'b0; valid_i = 1'b0; ALUOut = '0; DataOutReg2 = '0; PC = '0;
    funct3 = '0; MemWE = 1'b0; WBSel = 2'b01; RegWE = 1'b0; rd = '0;
    dmem_ready = 1'b0; dmem_rdata = '0;
    #12;
    checkOutput("reset req", dmem_req, 1'b0);
    checkOutput("reset stall", stall_o, 1'b0);
    checkOutput("reset we", we, 1'b0);
    checkOutput("reset pulses", {30'b0, misalign_o, bus_err_o}, 32'h0);
    checkOutput("reset addr", dmem_addr, 32'h0);
    checkOutput("reset wdata", dmem_wdata, 32'h0);
    checkOutput("reset be", dmem_be, 4'h0);
    checkOutput("reset WriteData", WriteData, 32'h0);
    checkOutput("reset WriteAddr", WriteAddr, 5'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] IDLE vectors");
    for (int i = 0; i < 13; i++) applyStimulus(i, vecs[i]);

    $display("[TB] load sequences");
    for (int i = 0; i < 7; i++) runLoad(i, loads[i]);

    $display("[TB] store sequences");
    runStore("SH", 3'b001, 32'h0000_0022, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
    runStore("SB", 3'b000, 32'h0000_0013, 32'h1234_56A5, 4'b1000, 32'hA5A5_A5A5);
    runStore("SW", 3'b010, 32'h0000_0044, 32'h1122_3344, 4'b1111, 32'h1122_3344);

    $display("[TB] timeout sequence");
    @(negedge clk);
    valid_i = 1'b1; MemWE = 1'b0; WBSel = 2'b00; RegWE = 1'b1; rd = 5'd20;
    funct3 = 3'b010; ALUOut = 32'h0000_0008; dmem_ready = 1'b0;
    @(negedge clk); #2;
    n = 1;
    stallDrops = 0;
    while (!bus_err_o && n < 40) begin
      if (!stall_o) stallDrops++;
      @(negedge clk); #2;
      n++;
    end
    checkOutput("timeout wait cycles", n, TIMEOUT);
    checkOutput("timeout stall held", stallDrops, 0);
    checkOutput("timeout bus_err", bus_err_o, 1'b1);
    checkOutput("timeout stall released", stall_o, 1'b0);
    checkOutput("timeout no we", we, 1'b0);
    @(negedge clk);
    valid_i = 1'b0;
    #2;
    checkOutput("timeout req dropped", dmem_req, 1'b0);
    checkOutput("timeout pulse width", bus_err_o, 1'b0);

    $display("[TB] reset during WAIT");
    @(negedge clk);
    valid_i = 1'b1; MemWE = 1'b0; WBSel = 2'b00; RegWE = 1'b1; rd = 5'd21;
    funct3 = 3'b010; ALUOut = 32'h0000_00C0;
    @(negedge clk); #2;
    checkOutput("pre-reset req", dmem_req, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("async reset req", dmem_req, 1'b0);
    checkOutput("async reset stall", stall_o, 1'b0);
    checkOutput("async reset addr", dmem_addr, 32'h0);
    @(negedge clk);
    valid_i = 1'b0;
    rst = 1'b1;
    #2;
    checkOutput("post-reset req", dmem_req, 1'b0);
    loads[0].rd = 5'd22;
    runLoad(7, loads[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiscompares);
    $finish;
  end

endmodule
